// File: rtl/clock_disp_pkg.sv
// rtl/clock_disp_pkg.sv - shared colours, colon geometry and 7-segment map for the clock overlay
package clock_disp_pkg;

    typedef logic [11:0] rgb_t;

    // Segment bit positions inside a seg[6:0] vector: seg[6] = a ... seg[0] = g
    typedef enum logic [2:0] {
        SEG_G = 3'd0,
        SEG_F = 3'd1,
        SEG_E = 3'd2,
        SEG_D = 3'd3,
        SEG_C = 3'd4,
        SEG_B = 3'd5,
        SEG_A = 3'd6
    } seg_idx_e;

    localparam rgb_t COLOUR_BLACK = 12'h000;
    localparam rgb_t COLOUR_WHITE = 12'hFFF;
    localparam rgb_t COLOUR_RED   = 12'hF00;

    // Colon dots sit just left of each field boundary xc, two dots stacked vertically
    localparam int COLON_DX_LO = 3;   // left column of a dot  = xc - 3
    localparam int COLON_DX_HI = 2;   // right column of a dot = xc - 2
    localparam int COLON_DY0   = 5;   // upper dot top row, relative to ORIGIN_Y
    localparam int COLON_DY1   = 11;  // lower dot top row, relative to ORIGIN_Y
    localparam int COLON_DOT_H = 2;

    // Stroke thickness of every segment
    localparam int SEG_T = 2;

    // BCD nibble to segment enables; anything above 9 lights nothing
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/clock_time_overlay_if.sv
// rtl/clock_time_overlay_if.sv - pixel position in, overlay colour out
interface clock_time_overlay_if;
    import clock_disp_pkg::*;

    logic       video_on;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    rgb_t       graph_rgb;

    modport master (
        output video_on,
        output pix_x,
        output pix_y,
        input  graph_rgb
    );

    modport slave (
        input  video_on,
        input  pix_x,
        input  pix_y,
        output graph_rgb
    );
endinterface

// File: rtl/clock_glyph_seg.sv
// rtl/clock_glyph_seg.sv - combinational 7-segment hit test for one digit box
module clock_glyph_seg
    import clock_disp_pkg::*;
#(
    parameter int GLYPH_W = 16,
    parameter int GLYPH_H = 16
) (
    input  logic [3:0] bcd_i,
    input  logic [9:0] pix_x_i,
    input  logic [9:0] pix_y_i,
    input  logic [9:0] x0_i,
    input  logic [9:0] y0_i,
    input  logic       box_en_i,
    output logic       on_o
);

    localparam logic [9:0] W_L   = 10'(GLYPH_W);
    localparam logic [9:0] H_L   = 10'(GLYPH_H);
    localparam logic [9:0] T_L   = 10'(SEG_T);
    localparam logic [9:0] XR_L  = 10'(GLYPH_W - SEG_T);
    localparam logic [9:0] YM_L  = 10'(GLYPH_H / 2);
    localparam logic [9:0] YB_L  = 10'(GLYPH_H - SEG_T);

    logic [9:0] dx;
    logic [9:0] dy;
    logic       in_box;
    logic       horiz;
    logic [6:0] lit;
    logic [6:0] seg;

    // Box-relative offsets, then per-segment stroke rectangles gated by the digit's segment map
    always_comb begin
        dx     = pix_x_i - x0_i;
        dy     = pix_y_i - y0_i;
        in_box = box_en_i && (pix_x_i >= x0_i) && (pix_y_i >= y0_i) &&
                 (dx < W_L) && (dy < H_L);
        horiz  = (dx >= T_L) && (dx < XR_L);
        seg    = bcd_to_seg(bcd_i);

        lit        = '0;
        lit[SEG_A] = horiz && (dy < T_L);
        lit[SEG_B] = (dx >= XR_L) && (dy >= T_L) && (dy < YM_L);
        lit[SEG_C] = (dx >= XR_L) && (dy >= YM_L) && (dy < YB_L);
        lit[SEG_D] = horiz && (dy >= YB_L);
        lit[SEG_E] = (dx < T_L) && (dy >= YM_L) && (dy < YB_L);
        lit[SEG_F] = (dx < T_L) && (dy >= T_L) && (dy < YM_L);
        lit[SEG_G] = horiz && (dy >= YM_L - 10'd1) && (dy <= YM_L);

        on_o = in_box && (|(seg & lit));
    end

endmodule

// File: rtl/clock_time_overlay.sv
// rtl/clock_time_overlay.sv - hh:mm:ss overlay with frame-latched digits and set-mode blink
module clock_time_overlay
    import clock_disp_pkg::*;
#(
    parameter int   NUM_FIELDS   = 3,
    parameter int   ORIGIN_X     = 270,
    parameter int   ORIGIN_Y     = 232,
    parameter int   DIGIT_PITCH  = 20,
    parameter int   FIELD_PITCH  = 40,
    parameter int   GLYPH_W      = 16,
    parameter int   GLYPH_H      = 16,
    parameter int   BLINK_FRAMES = 30,
    parameter rgb_t FG_RUN       = COLOUR_BLACK,
    parameter rgb_t FG_SET       = COLOUR_RED,
    parameter rgb_t BG           = COLOUR_WHITE
) (
    input  logic                    clk,
    input  logic                    reset,
    clock_time_overlay_if.slave     pix,
    input  logic                    frame_tick,
    input  logic                    settime,
    input  logic [1:0]              set_field,
    input  logic [NUM_FIELDS*8-1:0] digits_in
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [9:0] Y0_L = 10'(ORIGIN_Y);

    logic [NUM_FIELDS*8-1:0] digits_q, digits_d;
    logic [CNT_W-1:0]        blink_cnt_q, blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    rgb_t                    graph_rgb_q, graph_rgb_d;

    logic [NUM_FIELDS-1:0]   field_on;
    logic [NUM_FIELDS-1:0]   colon_hit;

    // Digits only change at frame boundaries so a frame never shows a half-updated time
    always_comb begin
        digits_d = frame_tick ? digits_in : digits_q;
    end

    // Blink timing: held clear outside set mode; in set mode counts frames, phase flips each half-period
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (!settime) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (frame_tick) begin
            if (blink_cnt_q == CNT_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // One pair of digit boxes per field; field 0 is the rightmost column
    for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_field
        localparam int COL     = NUM_FIELDS - 1 - f;
        localparam int X0_TENS = ORIGIN_X + COL * FIELD_PITCH;
        localparam int X0_UNIT = X0_TENS + DIGIT_PITCH;
        localparam logic EN_TENS = (X0_TENS <= 1023) && (ORIGIN_Y <= 1023);
        localparam logic EN_UNIT = (X0_UNIT <= 1023) && (ORIGIN_Y <= 1023);

        logic tens_on;
        logic units_on;
        logic hide;

        clock_glyph_seg #(
            .GLYPH_W (GLYPH_W),
            .GLYPH_H (GLYPH_H)
        ) u_tens (
            .bcd_i    (digits_q[8*f+4 +: 4]),
            .pix_x_i  (pix.pix_x),
            .pix_y_i  (pix.pix_y),
            .x0_i     (10'(X0_TENS)),
            .y0_i     (Y0_L),
            .box_en_i (EN_TENS),
            .on_o     (tens_on)
        );

        clock_glyph_seg #(
            .GLYPH_W (GLYPH_W),
            .GLYPH_H (GLYPH_H)
        ) u_units (
            .bcd_i    (digits_q[8*f +: 4]),
            .pix_x_i  (pix.pix_x),
            .pix_y_i  (pix.pix_y),
            .x0_i     (10'(X0_UNIT)),
            .y0_i     (Y0_L),
            .box_en_i (EN_UNIT),
            .on_o     (units_on)
        );

        // Only the field under edit disappears during the hidden blink phase
        assign hide        = settime && blink_phase_q && (int'(set_field) == f);
        assign field_on[f] = (tens_on || units_on) && !hide;
    end

    // Colon dots between adjacent fields; never blink
    for (genvar c = 0; c < NUM_FIELDS - 1; c++) begin : g_colon
        localparam int XC = ORIGIN_X + (c + 1) * FIELD_PITCH;
        localparam logic       EN    = (XC - COLON_DX_HI) <= 1023;
        localparam logic [9:0] CX_LO = 10'(XC - COLON_DX_LO);
        localparam logic [9:0] CX_HI = 10'(XC - COLON_DX_HI);
        localparam logic [9:0] CY0   = 10'(ORIGIN_Y + COLON_DY0);
        localparam logic [9:0] CY1   = 10'(ORIGIN_Y + COLON_DY1);
        localparam logic [9:0] DH    = 10'(COLON_DOT_H - 1);

        assign colon_hit[c] = EN &&
                              (pix.pix_x >= CX_LO) && (pix.pix_x <= CX_HI) &&
                              (((pix.pix_y >= CY0) && (pix.pix_y <= CY0 + DH)) ||
                               ((pix.pix_y >= CY1) && (pix.pix_y <= CY1 + DH)));
    end
    assign colon_hit[NUM_FIELDS-1] = 1'b0;

    // Colour priority: blanking black, then foreground on any hit, else background
    always_comb begin
        graph_rgb_d = BG;
        if (!pix.video_on) begin
            graph_rgb_d = COLOUR_BLACK;
        end else if ((|colon_hit) || (|field_on)) begin
            graph_rgb_d = settime ? FG_SET : FG_RUN;
        end
    end

    // State and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            digits_q      <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            graph_rgb_q   <= '0;
        end else begin
            digits_q      <= digits_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            graph_rgb_q   <= graph_rgb_d;
        end
    end

    assign pix.graph_rgb = graph_rgb_q;

endmodule
